// File: rtl/sim_uart_pkg.sv
// Shared UART simulation types, used by both the input responder and the output printer.
package sim_uart_pkg;
  typedef logic [7:0] uart_ch_t;
  localparam uart_ch_t UART_NO_CHAR = 8'hff;
endpackage

// File: rtl/sim_uart_in_responder_if.sv
// Host feeder and DUT read-request signals of the UART input responder.
interface sim_uart_in_responder_if;
  import sim_uart_pkg::*;

  // Handshake: host_push writes host_ch at the posedge with no backpressure; a full FIFO drops the byte.
  // io_uart_in_valid is a request that is always answered the same cycle; io_uart_in_ch is the
  // byte consumed at that posedge, or NO_CHAR when nothing is served and nothing is consumed.
  logic     host_push;
  uart_ch_t host_ch;
  logic     io_uart_in_valid;
  uart_ch_t io_uart_in_ch;

  modport master (
    output host_push,
    output host_ch,
    output io_uart_in_valid,
    input  io_uart_in_ch
  );

  modport slave (
    input  host_push,
    input  host_ch,
    input  io_uart_in_valid,
    output io_uart_in_ch
  );
endinterface

// File: rtl/sim_uart_fifo.sv
// Synchronous byte FIFO with a combinational head; writes while full are accepted only with a read.
module sim_uart_fifo
  import sim_uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  uart_ch_t               din,
  input  logic                   rd_en,
  output uart_ch_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  uart_ch_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            wr_ok;
  logic            rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_ok = rd_en && !empty;
  // A read on the same edge frees the slot, so a full FIFO can still take a write.
  assign wr_ok = wr_en && (!full || rd_ok);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sim_uart_in_responder.sv
// Answers DUT UART read requests from a host-fed FIFO, with optional post-pop gap to emulate baud rate.
module sim_uart_in_responder
  import sim_uart_pkg::*;
#(
  parameter int       DEPTH      = 16,
  parameter int       GAP_CYCLES = 0,
  parameter uart_ch_t NO_CHAR    = UART_NO_CHAR
) (
  input  logic                   clock,
  input  logic                   reset,
  sim_uart_in_responder_if.slave uart,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic [15:0]            drop_count
);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [GW-1:0] gap;
  uart_ch_t      head;
  logic          empty;
  logic          serve;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign serve   = !empty && (gap == '0);
  assign pop     = uart.io_uart_in_valid && serve;
  assign push_ok = uart.host_push && (!fifo_full || pop);
  assign drop    = uart.host_push && fifo_full && !pop;
  // No bypass: a byte pushed into an empty FIFO is only visible from the next cycle.
  assign uart.io_uart_in_ch = serve ? head : NO_CHAR;

  sim_uart_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (push_ok),
    .din   (uart.host_ch),
    .rd_en (pop),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (empty)
  );

  // Gap counts down every cycle regardless of requests; a pop can only happen at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap <= '0;
    end else if (pop) begin
      gap <= GW'(GAP_CYCLES);
    end else if (gap != '0) begin
      gap <= gap - GW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hffff)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_sim_uart_in_responder.sv
// Bench for sim_uart_in_responder: directed scenarios plus a randomized run against a queue model.
module tb_sim_uart_in_responder;
  import sim_uart_pkg::*;

  logic        clock;
  logic        reset;
  logic [4:0]  cnt_a, cnt_b;
  logic        full_a, full_b;
  logic [15:0] drop_a, drop_b;

  logic [7:0]  obs_ch;
  logic [4:0]  obs_cnt;
  logic        obs_full;
  logic [15:0] obs_drop;

  logic [7:0]  exp_q[$];
  int          checks;
  int          failures;

  sim_uart_in_responder_if if_a ();
  sim_uart_in_responder_if if_b ();

  sim_uart_in_responder #(.DEPTH(16), .GAP_CYCLES(0)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .uart       (if_a),
    .fifo_count (cnt_a),
    .fifo_full  (full_a),
    .drop_count (drop_a)
  );

  sim_uart_in_responder #(.DEPTH(16), .GAP_CYCLES(3)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .uart       (if_b),
    .fifo_count (cnt_b),
    .fifo_full  (full_b),
    .drop_count (drop_b)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    if_a.host_push = 1'b0; if_a.io_uart_in_valid = 1'b0; if_a.host_ch = 8'h00;
    if_b.host_push = 1'b0; if_b.io_uart_in_valid = 1'b0; if_b.host_ch = 8'h00;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Driver: apply inputs for the coming posedge and sample the pre-edge outputs.
  task automatic step(input bit sel_b, input bit p, input logic [7:0] c, input bit r);
    @(negedge clock);
    if_a.host_push = sel_b ? 1'b0 : p;
    if_a.host_ch   = c;
    if_a.io_uart_in_valid = sel_b ? 1'b0 : r;
    if_b.host_push = sel_b ? p : 1'b0;
    if_b.host_ch   = c;
    if_b.io_uart_in_valid = sel_b ? r : 1'b0;
    #1;
    obs_ch   = sel_b ? if_b.io_uart_in_ch : if_a.io_uart_in_ch;
    obs_cnt  = sel_b ? cnt_b : cnt_a;
    obs_full = sel_b ? full_b : full_a;
    obs_drop = sel_b ? drop_b : drop_a;
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 0, 8'h00, 1);
    checks++;
    if (obs_full !== 1'b0 || obs_drop !== 16'd0) begin
      failures++;
      $display("FAIL reset_flags full=%0b drop=%0d exp full=0 drop=0", obs_full, obs_drop);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step(0, 0, 8'h00, 1);
      checks++;
      if (obs_ch !== 8'hff || obs_cnt !== 5'd0) begin
        failures++;
        $display("FAIL reset_req[%0d] ch=%02h cnt=%0d exp ch=ff cnt=0", i, obs_ch, obs_cnt);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] msg [3];
    logic [7:0] e;
    msg[0] = 8'h68; msg[1] = 8'h69; msg[2] = 8'h0a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, msg[i], 0);
      exp_q.push_back(msg[i]);
    end
    exp_q.push_back(8'hff);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1);
      e = exp_q.pop_front();
      checks++;
      if (obs_ch !== e || obs_cnt !== 5'(3 - ((i < 3) ? i : 3))) begin
        failures++;
        $display("FAIL basic[%0d] ch=%02h cnt=%0d exp ch=%02h cnt=%0d", i, obs_ch, obs_cnt, e,
                 3 - ((i < 3) ? i : 3));
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'(i * 7 + 1), 0);
      if (i < 16) exp_q.push_back(8'(i * 7 + 1));
    end
    step(0, 0, 8'h00, 0);
    checks++;
    if (obs_cnt !== 5'd16 || obs_full !== 1'b1 || obs_drop !== 16'd4) begin
      failures++;
      $display("FAIL overflow_state cnt=%0d full=%0b drop=%0d exp cnt=16 full=1 drop=4",
               obs_cnt, obs_full, obs_drop);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 1);
      e = exp_q.pop_front();
      checks++;
      if (obs_ch !== e) begin
        failures++;
        $display("FAIL overflow_drain[%0d] ch=%02h exp=%02h", i, obs_ch, e);
      end
    end
    step(0, 0, 8'h00, 1);
    checks++;
    if (obs_ch !== 8'hff || obs_cnt !== 5'd0) begin
      failures++;
      $display("FAIL overflow_empty ch=%02h cnt=%0d exp ch=ff cnt=0", obs_ch, obs_cnt);
    end
  endtask

  task automatic test_gap();
    logic [7:0] e;
    do_reset();
    step(1, 1, 8'h41, 0);
    step(1, 1, 8'h42, 0);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'hff); exp_q.push_back(8'hff); exp_q.push_back(8'hff);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'hff);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 8'h00, 1);
      e = exp_q.pop_front();
      checks++;
      if (obs_ch !== e) begin
        failures++;
        $display("FAIL gap[%0d] ch=%02h exp=%02h", i, obs_ch, e);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(8'h80 + i), 0);
      exp_q.push_back(8'(8'h80 + i));
    end
    step(0, 1, 8'h55, 1);
    exp_q.push_back(8'h55);
    e = exp_q.pop_front();
    checks++;
    if (obs_ch !== e || obs_full !== 1'b1) begin
      failures++;
      $display("FAIL full_pushpop_head ch=%02h full=%0b exp ch=%02h full=1", obs_ch, obs_full, e);
    end
    step(0, 0, 8'h00, 0);
    checks++;
    if (obs_cnt !== 5'd16 || obs_drop !== 16'd0 || obs_full !== 1'b1) begin
      failures++;
      $display("FAIL full_pushpop_state cnt=%0d drop=%0d full=%0b exp cnt=16 drop=0 full=1",
               obs_cnt, obs_drop, obs_full);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 1);
      e = exp_q.pop_front();
      checks++;
      if (obs_ch !== e) begin
        failures++;
        $display("FAIL full_pushpop_drain[%0d] ch=%02h exp=%02h", i, obs_ch, e);
      end
    end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    step(0, 1, 8'h3c, 1);
    checks++;
    if (obs_ch !== 8'hff) begin
      failures++;
      $display("FAIL nobypass ch=%02h exp=ff", obs_ch);
    end
    step(0, 0, 8'h00, 1);
    checks++;
    if (obs_ch !== 8'h3c || obs_cnt !== 5'd1) begin
      failures++;
      $display("FAIL nobypass_next ch=%02h cnt=%0d exp ch=3c cnt=1", obs_ch, obs_cnt);
    end
    step(0, 1, 8'hff, 0);
    step(0, 0, 8'h00, 1);
    checks++;
    if (obs_ch !== 8'hff || obs_cnt !== 5'd1) begin
      failures++;
      $display("FAIL nochar_stored ch=%02h cnt=%0d exp ch=ff cnt=1", obs_ch, obs_cnt);
    end
    step(0, 0, 8'h00, 0);
    checks++;
    if (obs_cnt !== 5'd0) begin
      failures++;
      $display("FAIL nochar_popped cnt=%0d exp=0", obs_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 18; i++) step(0, 1, 8'(8'h20 + i), 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    checks++;
    if (obs_cnt !== 5'd14 || obs_drop !== 16'd2) begin
      failures++;
      $display("FAIL midreset_pre cnt=%0d drop=%0d exp cnt=14 drop=2", obs_cnt, obs_drop);
    end
    do_reset();
    step(0, 0, 8'h00, 1);
    checks++;
    if (obs_ch !== 8'hff || obs_cnt !== 5'd0 || obs_drop !== 16'd0 || obs_full !== 1'b0) begin
      failures++;
      $display("FAIL midreset_post ch=%02h cnt=%0d drop=%0d full=%0b exp ch=ff cnt=0 drop=0 full=0",
               obs_ch, obs_cnt, obs_drop, obs_full);
    end
  endtask

  // Randomized traffic: exp_q holds the bytes the host has had accepted, in order.
  task automatic test_back_to_back();
    bit         p, r, did_pop;
    logic [7:0] c, e;
    int         mdrop;
    do_reset();
    exp_q.delete();
    mdrop = 0;
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      c = 8'($urandom_range(0, 255));
      step(0, p, c, r);
      checks++;
      if (obs_cnt !== 5'(exp_q.size())) begin
        failures++;
        $display("FAIL rand_cnt[%0d] cnt=%0d exp=%0d", i, obs_cnt, exp_q.size());
      end
      did_pop = r && (exp_q.size() > 0);
      if (r) begin
        e = did_pop ? exp_q.pop_front() : 8'hff;
        checks++;
        if (obs_ch !== e) begin
          failures++;
          $display("FAIL rand_ch[%0d] ch=%02h exp=%02h", i, obs_ch, e);
        end
      end
      if (p) begin
        if (exp_q.size() < 16) exp_q.push_back(c);
        else mdrop++;
      end
    end
    step(0, 0, 8'h00, 0);
    checks++;
    if (obs_drop !== 16'(mdrop)) begin
      failures++;
      $display("FAIL rand_drop drop=%0d exp=%0d", obs_drop, mdrop);
    end
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    if_a.host_push = 1'b0; if_a.host_ch = 8'h00; if_a.io_uart_in_valid = 1'b0;
    if_b.host_push = 1'b0; if_b.host_ch = 8'h00; if_b.io_uart_in_valid = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_gap();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
